// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: tracks in-flight destination registers with a latency
// countdown and produces issue stall and per-source forwarding selects.
module hazard_scoreboard #(
    parameter int REGFILE_LEN          = 5,
    parameter int NUM_SRC              = 2,
    parameter int LAT_WIDTH            = 3,
    parameter int FORWARD_SELECT_WIDTH = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   issue_valid,
    input  logic [REGFILE_LEN-1:0]                 issue_rd,
    input  logic [LAT_WIDTH-1:0]                   issue_lat,
    input  logic [NUM_SRC*REGFILE_LEN-1:0]         src_addr,
    input  logic                                   wb_valid,
    input  logic [REGFILE_LEN-1:0]                 wb_rd,
    input  logic                                   flush,
    output logic                                   stall,
    output logic [NUM_SRC*FORWARD_SELECT_WIDTH-1:0] forward_sel,
    output logic [REGFILE_LEN:0]                   pending_count
);

    localparam int NUM_ENTRIES = 1 << REGFILE_LEN;
    localparam logic [FORWARD_SELECT_WIDTH-1:0] FWD_RESULT = FORWARD_SELECT_WIDTH'(2);
    localparam logic [FORWARD_SELECT_WIDTH-1:0] FWD_WB     = FORWARD_SELECT_WIDTH'(1);

    logic [NUM_ENTRIES-1:0] r_pending;
    logic [LAT_WIDTH-1:0]   r_cnt [NUM_ENTRIES];
    logic [REGFILE_LEN:0]   r_pending_count;

    logic                   w_any_hazard;
    logic                   w_waw;
    logic                   w_accept;
    logic [LAT_WIDTH-1:0]   w_load_cnt;
    logic [NUM_ENTRIES-1:0] w_pend_nxt;
    logic [LAT_WIDTH-1:0]   w_cnt_nxt [NUM_ENTRIES];
    logic [REGFILE_LEN:0]   w_count_nxt;

    // Source checks: a writeback to the same register resolves the hazard this cycle.
    always_comb begin
        w_any_hazard = 1'b0;
        forward_sel  = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            logic [REGFILE_LEN-1:0] src;
            logic                   wb_hit;
            src    = src_addr[s*REGFILE_LEN +: REGFILE_LEN];
            wb_hit = wb_valid && (wb_rd == src);
            if (src != '0) begin
                if (wb_hit) begin
                    forward_sel[s*FORWARD_SELECT_WIDTH +: FORWARD_SELECT_WIDTH] = FWD_WB;
                end else if (r_pending[src] && (r_cnt[src] == '0)) begin
                    forward_sel[s*FORWARD_SELECT_WIDTH +: FORWARD_SELECT_WIDTH] = FWD_RESULT;
                end
                if (r_pending[src] && (r_cnt[src] != '0) && !wb_hit) begin
                    w_any_hazard = 1'b1;
                end
            end
        end
        w_waw = (issue_rd != '0) && r_pending[issue_rd] && !(wb_valid && (wb_rd == issue_rd));
        stall = rst_n && issue_valid && (w_any_hazard || w_waw);
        if (!rst_n) begin
            forward_sel = '0;
        end
    end

    // Next-state: decrement, then writeback and flush clears, then an accepted issue wins.
    always_comb begin
        w_accept    = issue_valid && !stall && (issue_rd != '0) && !flush;
        w_load_cnt  = (issue_lat == '0) ? '0 : issue_lat - LAT_WIDTH'(1);
        w_count_nxt = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_pend_nxt[i] = r_pending[i];
            w_cnt_nxt[i]  = (r_cnt[i] != '0) ? r_cnt[i] - LAT_WIDTH'(1) : '0;
            if (wb_valid && (wb_rd == REGFILE_LEN'(i))) begin
                w_pend_nxt[i] = 1'b0;
                w_cnt_nxt[i]  = '0;
            end
            if (flush && (r_cnt[i] != '0)) begin
                w_pend_nxt[i] = 1'b0;
                w_cnt_nxt[i]  = '0;
            end
            if (w_accept && (issue_rd == REGFILE_LEN'(i))) begin
                w_pend_nxt[i] = 1'b1;
                w_cnt_nxt[i]  = w_load_cnt;
            end
            w_count_nxt = w_count_nxt + (REGFILE_LEN+1)'(w_pend_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending       <= '0;
            r_pending_count <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_pending       <= w_pend_nxt;
            r_pending_count <= w_count_nxt;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign pending_count = r_pending_count;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REGFILE_LEN, default 5, register address width; 2^REGFILE_LEN scoreboard entries.
REQ-002 SHALL have parameter NUM_SRC, default 2, number of source operands checked per cycle.
REQ-003 SHALL have parameter LAT_WIDTH, default 3, width of the latency field and per-entry countdown.
REQ-004 SHALL have parameter FORWARD_SELECT_WIDTH, default 2, width of each per-source forward select.
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-008 SHALL have port issue_valid, input, 1, an instruction writing a register is issuing.
REQ-009 SHALL have port issue_rd, input, REGFILE_LEN, destination register of the issuing instruction.
REQ-010 SHALL have port issue_lat, input, LAT_WIDTH, cycles until the result appears on the result bus.
REQ-011 SHALL have port src_addr, input, NUM_SRC*REGFILE_LEN, source registers; source s occupies bits [s*REGFILE_LEN +: REGFILE_LEN].
REQ-012 SHALL have port wb_valid, input, 1, a result is being written back this cycle.
REQ-013 SHALL have port wb_rd, input, REGFILE_LEN, register being written back.
REQ-014 SHALL have port flush, input, 1, squash all in-flight results not yet produced.
REQ-015 SHALL have port stall, output, 1, hold the issuing instruction.
REQ-016 SHALL have port forward_sel, output, NUM_SRC*FORWARD_SELECT_WIDTH, per-source select: 00 regfile, 10 result bus, 01 writeback bus.
REQ-017 SHALL have port pending_count, output, REGFILE_LEN+1, number of entries with pending set (registered).

Function
REQ-018 Each entry SHALL hold a pending bit and a LAT_WIDTH countdown cnt.
REQ-019 Register x0 SHALL never become pending; sources equal to 0 SHALL always give forward_sel 00 and cause no stall.
REQ-020 A source a (non-zero) SHALL be hazardous when pending[a]=1 and cnt[a]!=0 and not (wb_valid and wb_rd==a).
REQ-021 forward_sel for source a SHALL be: 01 if wb_valid and wb_rd==a; else 10 if pending[a] and cnt[a]==0; else 00.
REQ-022 stall SHALL be 1 when issue_valid=1 and any source is hazardous, or when issue_valid=1, issue_rd!=0, pending[issue_rd]=1 and not (wb_valid and wb_rd==issue_rd) (WAW).
REQ-023 stall and forward_sel SHALL be combinational from registered state and current inputs (zero-cycle latency).
REQ-024 On an accepted issue (issue_valid=1, stall=0, issue_rd!=0), next cycle pending[issue_rd]=1 and cnt[issue_rd]=max(issue_lat,1)-1.
REQ-025 Each cycle every pending entry not being issued SHALL decrement cnt, saturating at 0.
REQ-026 wb_valid with wb_rd!=0 SHALL clear pending[wb_rd] and cnt[wb_rd] next cycle.
REQ-027 Simultaneous accepted issue and writeback to the same rd: issue SHALL win (entry reloaded per REQ-024).
REQ-028 flush=1 SHALL clear every entry with cnt!=0 next cycle; entries with cnt==0 SHALL remain pending until writeback; an issue in the flush cycle SHALL be discarded.
REQ-029 flush and writeback in the same cycle SHALL both take effect.
REQ-030 pending_count SHALL equal the popcount of pending bits after each update, never exceeding 2^REGFILE_LEN-1.
REQ-031 An issue while stall=1 SHALL leave scoreboard state unchanged except for decrement, writeback and flush effects.

Reset
REQ-032 While rst_n=0 at a clock edge, all pending bits, all cnt, and pending_count SHALL clear to 0.
REQ-033 While rst_n=0, stall SHALL be 0 and forward_sel all 0, regardless of inputs.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight entries; the first cycle after release SHALL report no hazards.

Verification
REQ-035 Issue rd=5 lat=3; next cycle src0=5 -> stall=1 for 2 cycles, then stall=0 and forward_sel[1:0]=10.
REQ-036 Entry 5 pending cnt=0, wb_valid wb_rd=5, src1=5 -> forward_sel[3:2]=01, stall=0; next cycle entry cleared, forward_sel=00.
REQ-037 Issue rd=0 lat=4; src0=0 -> no entry created, pending_count=0, stall=0, forward_sel=00.
REQ-038 Entry 7 pending cnt=2, issue rd=7 -> stall=1 (WAW); same with wb_valid wb_rd=7 -> stall=0 and entry 7 reloaded.
REQ-039 Entries 3 (cnt=2) and 4 (cnt=0) pending, flush=1 -> next cycle only entry 4 pending, pending_count=1.
REQ-040 Three entries pending, rst_n=0 for one cycle -> pending_count=0, stall=0, forward_sel=00 after release.
